ex_div_iter: RTL and testbench

Parametrised iterative restoring divider for the EX stage. It replaces the vendor-IP-backed fixed 32-bit divider with self-contained RTL that has an explicit start/ready/done handshake and a flush input for pipeline squash. It defines divide-by-zero behaviour and reports it with a flag. Results use the HI/LO packing `{remainder, quotient}` consumed by the HI/LO write-back path.

---
 rtl/ex_div_iter_if.sv | 45 ++++
 rtl/ex_div_iter.sv | 165 ++++++++++++++++
 tb/tb_ex_div_iter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_iter_if.sv
// ----------------------------------------------------------------------------
// ex_div_iter_if
// Handshake and data bundle for the iterative EX-stage divider.
//   master : requester side (drives start/flush/operands, sees status/results)
//   slave  : divider side
// Signals:
//   flush      abort the division in flight, no done follows
//   start      request a division (taken only while ready=1)
//   signed_op  1 = signed DIV, 0 = unsigned DIVU
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   ready      divider idle, a start is accepted this cycle
//   busy       divider iterating or finishing (~ready)
//   done       one-cycle pulse when quotient/remainder update
//   div_zero   last result came from a divide by zero
//   quotient   last quotient
//   remainder  last remainder
//   result     {remainder, quotient} for the HI/LO write-back path
// ----------------------------------------------------------------------------
interface ex_div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 flush;
    logic                 start;
    logic                 signed_op;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 div_zero;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output flush, start, signed_op, dividend, divisor,
        input  ready, busy, done, div_zero, quotient, remainder, result
    );

    modport slave (
        input  flush, start, signed_op, dividend, divisor,
        output ready, busy, done, div_zero, quotient, remainder, result
    );
endinterface

// File: rtl/ex_div_iter.sv
// ----------------------------------------------------------------------------
// ex_div_iter
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Latency from the accepting cycle to the done pulse is WIDTH+2 cycles,
// independent of operand values. Divide by zero returns an all-ones quotient
// and the raw dividend as remainder, flagged by div_zero.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  ex_div_iter_if.slave (start/flush/operands in, status/results out)
// Parameter:
//   WIDTH  operand width in bits, 8..64
// ----------------------------------------------------------------------------
module ex_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             iter_en;
    logic             fix_en;

    // Working registers: partial remainder, dividend/quotient shift register,
    // divisor magnitude, raw dividend and the captured sign/zero flags.
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             q_neg;
    logic             r_neg;
    logic             zero;

    logic                  done_r;
    logic                  div_zero_r;
    logic [WIDTH-1:0]      quo_r;
    logic [WIDTH-1:0]      rem_r;

    logic signed [WIDTH+1:0] shifted;
    logic signed [WIDTH+1:0] trial;
    logic                    trial_ok;

    // Magnitude of a signed operand; unsigned operands pass through.
    // |MIN| = 2^(WIDTH-1) stays representable as a WIDTH-bit unsigned value.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                                input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // Two's complement sign correction, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? -v : v;
    endfunction

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_nxt = S_ITER;
                S_ITER:  if (cnt == CNT_W'(1)) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---- FSM: outputs and datapath enables ----
    always_comb begin
        bus.ready = (state == S_IDLE);
        bus.busy  = (state != S_IDLE);
        load      = (state == S_IDLE) && bus.start && !bus.flush;
        iter_en   = (state == S_ITER) && !bus.flush;
        fix_en    = (state == S_FIX)  && !bus.flush;
    end

    // ---- iteration counter ----
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WIDTH);
        end else if (iter_en) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // ---- restoring step ----
    // The top bit of the shifted value is always zero (rem < divisor), so the
    // sign of trial alone tells whether the subtraction fits.
    always_comb begin
        shifted  = {rem, q_sh[WIDTH-1]};
        trial    = shifted - $signed({2'b00, dvsr_mag});
        trial_ok = !trial[WIDTH+1];
    end

    // ---- operand capture / iteration ----
    always_ff @(posedge clk) begin
        if (load) begin
            rem      <= '0;
            q_sh     <= mag_of(bus.dividend, bus.signed_op);
            dvsr_mag <= mag_of(bus.divisor,  bus.signed_op);
            dvd_raw  <= bus.dividend;
            q_neg    <= bus.signed_op && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg    <= bus.signed_op && bus.dividend[WIDTH-1];
            zero     <= (bus.divisor == '0);
        end else if (iter_en) begin
            rem  <= trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
            q_sh <= {q_sh[WIDTH-2:0], trial_ok};
        end
    end

    // ---- result fix-up and output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            quo_r      <= '0;
            rem_r      <= '0;
        end else begin
            done_r <= fix_en;
            if (fix_en) begin
                div_zero_r <= zero;
                if (zero) begin
                    quo_r <= '1;
                    rem_r <= dvd_raw;
                end else begin
                    quo_r <= sign_fix(q_sh, q_neg);
                    rem_r <= sign_fix(rem[WIDTH-1:0], r_neg);
                end
            end
        end
    end

    assign bus.done      = done_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.result    = {rem_r, quo_r};

endmodule

// File: tb/tb_ex_div_iter.sv
// ----------------------------------------------------------------------------
// tb_ex_div_iter
// Scoreboard bench for ex_div_iter: a WIDTH=32 and a WIDTH=8 instance.
// Expected results (and the cycle of their done pulse) are queued when a
// start is driven and compared when done appears.
// ----------------------------------------------------------------------------
module tb_ex_div_iter;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
        longint      cyc;
    } exp_t;

    logic   clk;
    logic   rst32;
    logic   rst8;
    longint cyc;
    int     n_chk;
    int     n_pass;

    exp_t sb32[$];
    exp_t sb8[$];

    ex_div_iter_if #(.WIDTH(32)) if32();
    ex_div_iter_if #(.WIDTH(8))  if8();

    ex_div_iter #(.WIDTH(32)) u_div32 (
        .clk (clk),
        .rst (rst32),
        .bus (if32)
    );

    ex_div_iter #(.WIDTH(8)) u_div8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: native SV division on sign/zero-extended operands.
    function automatic exp_t model(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input bit s);
        exp_t        e;
        logic [63:0] mask;
        longint      sa;
        longint      sb;
        mask = (64'd1 << w) - 64'd1;
        a    = a & mask;
        b    = b & mask;
        e.z  = 1'b0;
        e.cyc = 0;
        if (b == 64'd0) begin
            e.q = mask;
            e.r = a;
            e.z = 1'b1;
        end else if (s) begin
            sa  = $signed(a << (64 - w)) >>> (64 - w);
            sb  = $signed(b << (64 - w)) >>> (64 - w);
            e.q = 64'(sa / sb) & mask;
            e.r = 64'(sa % sb) & mask;
        end else begin
            e.q = (a / b) & mask;
            e.r = (a % b) & mask;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive32(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input bit push);
        exp_t e;
        if32.start     = 1'b1;
        if32.signed_op = s;
        if32.dividend  = a;
        if32.divisor   = b;
        if (push) begin
            e     = model(32, {32'd0, a}, {32'd0, b}, s);
            e.cyc = cyc + 34;
            sb32.push_back(e);
        end
        tick();
        if32.start    = 1'b0;
        if32.dividend = 32'hDEAD_BEEF;
        if32.divisor  = 32'h0BAD_F00D;
    endtask

    task automatic drive8(input bit s, input logic [7:0] a, input logic [7:0] b,
                          input bit push);
        exp_t e;
        if8.start     = 1'b1;
        if8.signed_op = s;
        if8.dividend  = a;
        if8.divisor   = b;
        if (push) begin
            e     = model(8, {56'd0, a}, {56'd0, b}, s);
            e.cyc = cyc + 10;
            sb8.push_back(e);
        end
        tick();
        if8.start    = 1'b0;
        if8.dividend = 8'hA5;
        if8.divisor  = 8'h5A;
    endtask

    task automatic drain32();
        for (int i = 0; i < 200 && sb32.size() != 0; i++) tick();
        chk("drain32", 64'(sb32.size()), 64'd0);
    endtask

    task automatic drain8();
        for (int i = 0; i < 50 && sb8.size() != 0; i++) tick();
        chk("drain8", 64'(sb8.size()), 64'd0);
    endtask

    // Result monitors, sampled on the falling edge.
    logic prev_done32 = 1'b0;
    logic prev_done8  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (if32.done) begin
            chk("done32_twice", 64'(prev_done32), 64'd0);
            if (sb32.size() == 0) begin
                chk("unexpected_done32", 64'd1, 64'd0);
            end else begin
                e = sb32.pop_front();
                chk("cyc32", 64'(cyc), 64'(e.cyc));
                chk("q32", 64'(if32.quotient), e.q);
                chk("r32", 64'(if32.remainder), e.r);
                chk("dz32", 64'(if32.div_zero), 64'(e.z));
                chk("res32", if32.result, {e.r[31:0], e.q[31:0]});
                chk("ready32_at_done", 64'(if32.ready), 64'd1);
            end
        end
        prev_done32 <= if32.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (if8.done) begin
            chk("done8_twice", 64'(prev_done8), 64'd0);
            if (sb8.size() == 0) begin
                chk("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e = sb8.pop_front();
                chk("cyc8", 64'(cyc), 64'(e.cyc));
                chk("q8", 64'(if8.quotient), e.q);
                chk("r8", 64'(if8.remainder), e.r);
                chk("dz8", 64'(if8.div_zero), 64'(e.z));
            end
        end
        prev_done8 <= if8.done;
    end

    task automatic chk_reset8(input string tag);
        chk({tag, "_ready"}, 64'(if8.ready), 64'd1);
        chk({tag, "_busy"}, 64'(if8.busy), 64'd0);
        chk({tag, "_done"}, 64'(if8.done), 64'd0);
        chk({tag, "_dz"}, 64'(if8.div_zero), 64'd0);
        chk({tag, "_q"}, 64'(if8.quotient), 64'd0);
        chk({tag, "_r"}, 64'(if8.remainder), 64'd0);
        chk({tag, "_res"}, 64'(if8.result), 64'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst32  = 1'b1;
        rst8   = 1'b1;
        {if32.start, if32.flush, if32.signed_op} = 3'b000;
        if32.dividend = '0;
        if32.divisor  = '0;
        {if8.start, if8.flush, if8.signed_op} = 3'b000;
        if8.dividend = '0;
        if8.divisor  = '0;
        ticks(3);
        rst32 = 1'b0;
        rst8  = 1'b0;
        tick();

        // Reset state
        chk("rst32_ready", 64'(if32.ready), 64'd1);
        chk("rst32_busy", 64'(if32.busy), 64'd0);
        chk("rst32_done", 64'(if32.done), 64'd0);
        chk("rst32_dz", 64'(if32.div_zero), 64'd0);
        chk("rst32_res", if32.result, 64'd0);
        chk_reset8("rst8");

        // Unsigned 100 / 7
        drive32(1'b0, 32'd100, 32'd7, 1'b1);
        chk("busy32_after_start", 64'(if32.busy), 64'd1);
        drain32();
        chk("res_100_7", if32.result, 64'h0000_0002_0000_000E);

        // Signed sign matrix and MIN / -1
        drive32(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        drain32();
        chk("q_m7_2", 64'(if32.quotient), 64'h0000_0000_FFFF_FFFD);
        chk("r_m7_2", 64'(if32.remainder), 64'h0000_0000_FFFF_FFFF);
        drive32(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        drain32();
        chk("q_7_m2", 64'(if32.quotient), 64'h0000_0000_FFFF_FFFD);
        chk("r_7_m2", 64'(if32.remainder), 64'd1);
        drive32(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
        drain32();
        chk("q_m7_m2", 64'(if32.quotient), 64'd3);
        chk("r_m7_m2", 64'(if32.remainder), 64'h0000_0000_FFFF_FFFF);
        drive32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain32();
        chk("q_min_m1", 64'(if32.quotient), 64'h0000_0000_8000_0000);
        chk("r_min_m1", 64'(if32.remainder), 64'd0);

        // Divide by zero, then a normal divide clears the flag
        drive32(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1);
        drain32();
        chk("dz_flag", 64'(if32.div_zero), 64'd1);
        chk("dz_q", 64'(if32.quotient), 64'h0000_0000_FFFF_FFFF);
        chk("dz_r", 64'(if32.remainder), 64'h0000_0000_FFFF_FFF9);
        drive32(1'b1, 32'd9, 32'd3, 1'b1);
        drain32();
        chk("dz_cleared", 64'(if32.div_zero), 64'd0);

        // Back-to-back: second start lands in the done cycle
        drive32(1'b0, 32'd12345, 32'd17, 1'b1);
        ticks(33);
        drive32(1'b1, 32'hFFFF_D000, 32'd100, 1'b1);
        drain32();

        // Starts while busy are ignored
        drive32(1'b0, 32'd1000, 32'd10, 1'b1);
        ticks(4);
        drive32(1'b1, 32'd5, 32'd1, 1'b0);
        ticks(14);
        drive32(1'b0, 32'd77, 32'd0, 1'b0);
        drain32();
        ticks(40);
        chk("ignored_q", 64'(if32.quotient), 64'd100);

        // Flush at cycle 17: no done, outputs held, ready next cycle
        drive32(1'b0, 32'd55, 32'd5, 1'b0);
        ticks(16);
        if32.flush = 1'b1;
        tick();
        if32.flush = 1'b0;
        chk("flush_ready", 64'(if32.ready), 64'd1);
        chk("flush_q_held", 64'(if32.quotient), 64'd100);
        chk("flush_r_held", 64'(if32.remainder), 64'd0);
        chk("flush_dz_held", 64'(if32.div_zero), 64'd0);
        ticks(40);
        drive32(1'b0, 32'd85, 32'd9, 1'b1);
        drain32();

        // Flush in the FIX cycle suppresses the update
        drive32(1'b0, 32'd77, 32'd7, 1'b0);
        ticks(32);
        if32.flush = 1'b1;
        tick();
        if32.flush = 1'b0;
        ticks(3);
        chk("fixflush_q", 64'(if32.quotient), 64'd9);
        chk("fixflush_r", 64'(if32.remainder), 64'd4);

        // Flush together with start in IDLE: nothing begins
        if32.flush = 1'b1;
        drive32(1'b0, 32'd50, 32'd5, 1'b0);
        if32.flush = 1'b0;
        chk("flushstart_ready", 64'(if32.ready), 64'd1);
        ticks(40);
        chk("flushstart_q", 64'(if32.quotient), 64'd9);

        // WIDTH=8 random sweep, back-to-back
        for (int i = 0; i < 2000; i++) begin
            drive8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
            ticks(9);
        end
        drain8();

        // Reset mid-ITER returns outputs to reset values with no done
        drive8(1'b1, 8'h9C, 8'h07, 1'b0);
        ticks(4);
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        chk_reset8("midrst8");
        ticks(15);
        chk("midrst8_q_still0", 64'(if8.quotient), 64'd0);

        // 8-bit MIN / -1
        drive8(1'b1, 8'h80, 8'hFF, 1'b1);
        drain8();
        chk("q8_min_m1", 64'(if8.quotient), 64'h80);

        ticks(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
